adder_pipe_arbiter: RTL and testbench

ADDER_PIPE_ARBITER -- requirements
Module: adder_pipe_arbiter

---
 rtl/adder_pipe_arbiter.sv | 153 +++++++++++++++
 tb/tb_adder_pipe_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_arbiter.sv
// Round-robin arbiter sharing one LAT-deep 16-bit adder; results return in issue order via a credit-guarded FIFO (LAT+1 cycles min).
// Requests stall when FIFO entries plus in-flight adds reach FIFO_DEPTH; define ADDER_ARB_STATS_EN for stat_issued/stat_stall.
module adder_pipe_arbiter #(
  parameter int N_REQ      = 4,
  parameter int LAT        = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [16*N_REQ-1:0]        req_x,
  input  logic [16*N_REQ-1:0]        req_y,
  input  logic [N_REQ-1:0]           req_cin,
  output logic [15:0]                add_x,
  output logic [15:0]                add_y,
  output logic                       add_c,
  input  logic [15:0]                add_s,
  input  logic                       add_cout,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [15:0]                rsp_sum,
  output logic                       rsp_cout
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [15:0]                stat_issued,
  output logic [15:0]                stat_stall
`endif
);
  localparam int IDW = $clog2(N_REQ);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  logic [IDW-1:0] r_last;
  logic [LAT-1:0] r_tag_vld;
  logic [IDW-1:0] r_tag_id [LAT];
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  r_inflight;
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [IDW-1:0] r_mem_id   [FIFO_DEPTH];
  logic [15:0]    r_mem_sum  [FIFO_DEPTH];
  logic           r_mem_cout [FIFO_DEPTH];

  logic           w_credit;
  logic           w_found;
  logic           w_issue;
  logic           w_push;
  logic           w_pop;
  logic [IDW-1:0] w_gnt;

  // Credits come only from registered occupancy, so a pop frees a slot one cycle later.
  assign w_credit = ({1'b0, r_count} + {1'b0, r_inflight}) < (CW+1)'(FIFO_DEPTH);
  assign w_issue  = !rst && w_found && w_credit;
  assign w_push   = r_tag_vld[LAT-1];

  // Two passes: indices above the last grant first, then wrap to the rest.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req_valid[i] && (IDW'(i) > r_last)) begin
        w_found = 1'b1;
        w_gnt   = IDW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req_valid[i] && (IDW'(i) <= r_last)) begin
        w_found = 1'b1;
        w_gnt   = IDW'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    add_x     = '0;
    add_y     = '0;
    add_c     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_issue && (w_gnt == IDW'(i))) begin
        req_ready[i] = 1'b1;
        add_x        = req_x[16*i +: 16];
        add_y        = req_y[16*i +: 16];
        add_c        = req_cin[i];
      end
    end
  end

  assign rsp_valid = !rst && (r_count != '0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign rsp_id    = rsp_valid ? r_mem_id[r_rptr]   : '0;
  assign rsp_sum   = rsp_valid ? r_mem_sum[r_rptr]  : '0;
  assign rsp_cout  = rsp_valid ? r_mem_cout[r_rptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= IDW'(N_REQ - 1);
      r_tag_vld  <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      if (w_issue) r_last <= w_gnt;
      r_tag_vld[0] <= w_issue;
      for (int k = 1; k < LAT; k++) r_tag_vld[k] <= r_tag_vld[k-1];
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset: validity lives in the tag bits and FIFO count.
  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_gnt;
    for (int k = 1; k < LAT; k++) r_tag_id[k] <= r_tag_id[k-1];
    if (w_push) begin
      r_mem_id[r_wptr]   <= r_tag_id[LAT-1];
      r_mem_sum[r_wptr]  <= add_s;
      r_mem_cout[r_wptr] <= add_cout;
    end
  end

`ifdef ADDER_ARB_STATS_EN
  logic [15:0] r_stat_issued;
  logic [15:0] r_stat_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_issued <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_issue && (r_stat_issued != 16'hFFFF)) r_stat_issued <= r_stat_issued + 16'd1;
      if ((|req_valid) && !w_issue && (r_stat_stall != 16'hFFFF)) r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_adder_pipe_arbiter.sv
// Directed bench for adder_pipe_arbiter with a behavioural 4-stage adder; stats checks apply when ADDER_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module tb_adder_pipe_arbiter;
  localparam int N   = 4;
  localparam int LAT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [16*N-1:0]   req_x;
  logic [16*N-1:0]   req_y;
  logic [N-1:0]      req_cin;
  logic [15:0]       add_x;
  logic [15:0]       add_y;
  logic              add_c;
  logic [15:0]       add_s;
  logic              add_cout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [15:0]       rsp_sum;
  logic              rsp_cout;
`ifdef ADDER_ARB_STATS_EN
  logic [15:0]       stat_issued;
  logic [15:0]       stat_stall;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_pipe_arbiter #(.N_REQ(N), .LAT(LAT), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
    .add_x(add_x), .add_y(add_y), .add_c(add_c),
    .add_s(add_s), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
`ifdef ADDER_ARB_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  // Behavioural shared adder: operands seen in cycle t appear on add_s during cycle t+LAT.
  logic [16:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_x} + {1'b0, add_y} + {16'd0, add_c};
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign add_s    = pipe[LAT-1][15:0];
  assign add_cout = pipe[LAT-1][16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [15:0] x, input logic [15:0] y, input logic c);
    req_x[16*i +: 16] = x;
    req_y[16*i +: 16] = y;
    req_cin[i]        = c;
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = N-1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int g[$];
    int r[$];
    int s[$];
`ifdef ADDER_ARB_STATS_EN
    logic [15:0] st0;
`endif
    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_cin = '0; rsp_ready = 1'b0;

    // Reset holds handshakes and adder inputs low even with requests pending.
    nxt(); req_valid = '1; set_op(2, 16'h5555, 16'h1111, 1'b1); smp();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_add_x", add_x, 0);
    chk("rst_add_c", add_c, 0);
    nxt(); smp();
`ifdef ADDER_ARB_STATS_EN
    chk("rst_stat_issued", stat_issued, 0);
    chk("rst_stat_stall", stat_stall, 0);
`endif

    // Single request from requester 0, response held under rsp_ready=0.
    nxt(); rst = 1'b0; req_valid = 4'b0001; set_op(0, 16'h1234, 16'h0FFF, 1'b1); smp();
    chk("single_grant", req_ready, 4'b0001);
    chk("single_add_x", add_x, 16'h1234);
    chk("single_add_y", add_y, 16'h0FFF);
    chk("single_add_c", add_c, 1);
    for (int c = 1; c <= 4; c++) begin
      nxt(); req_valid = '0; smp();
      chk("single_early_vld", rsp_valid, 0);
      chk("idle_rsp_sum", rsp_sum, 0);
      chk("idle_add_x", add_x, 0);
    end
    nxt(); smp();
    chk("single_vld", rsp_valid, 1);
    chk("single_id", rsp_id, 0);
    chk("single_sum", rsp_sum, 16'h2234);
    chk("single_cout", rsp_cout, 0);
    nxt(); smp();
    chk("hold_vld", rsp_valid, 1);
    chk("hold_sum", rsp_sum, 16'h2234);
    nxt(); rsp_ready = 1'b1; smp();
    chk("pop_vld", rsp_valid, 1);
    nxt(); smp();
    chk("after_pop_vld", rsp_valid, 0);
    chk("after_pop_id", rsp_id, 0);

    // Carry-out on requester 3; pointer is at 0 so 3 is the only candidate.
    nxt(); req_valid = 4'b1000; set_op(3, 16'hFFFF, 16'h0001, 1'b0); smp();
    chk("carry_grant", req_ready, 4'b1000);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      nxt(); req_valid = '0; smp();
      if (rsp_valid && lat == 0) begin
        lat = c;
        chk("carry_id", rsp_id, 3);
        chk("carry_sum", rsp_sum, 16'h0000);
        chk("carry_cout", rsp_cout, 1);
      end
    end
    chk("carry_latency", lat, 5);

    // Round robin with every requester valid: x=0x1000*(i+1), y=i.
    for (int i = 0; i < N; i++) set_op(i, 16'(16'h1000 * (i + 1)), 16'(i), 1'b0);
    for (int c = 0; c < 100 && r.size() < 8; c++) begin
      nxt(); req_valid = (g.size() < 8) ? '1 : '0; smp();
      chk("rr_onehot", 32'($countones(req_ready) <= 1), 1);
      if (req_ready != '0) begin
        n = oh2i(req_ready);
        chk("rr_add_x", add_x, 16'h1000 * (n + 1));
        g.push_back(n);
      end
      if (rsp_valid && rsp_ready) begin
        r.push_back(rsp_id);
        s.push_back(rsp_sum);
      end
    end
    chk("rr_grant_count", g.size(), 8);
    chk("rr_rsp_count", r.size(), 8);
    for (int k = 0; k < g.size(); k++) chk("rr_grant_order", g[k], k % 4);
    for (int k = 0; k < r.size(); k++) begin
      chk("rr_rsp_id", r[k], k % 4);
      chk("rr_rsp_sum", s[k], 16'h1000 * ((k % 4) + 1) + (k % 4));
    end

    // Back-pressure: only FIFO_DEPTH issues fit while nothing is popped.
    n = 0;
    for (int c = 0; c < 12; c++) begin
      nxt(); rsp_ready = 1'b0; req_valid = '1; smp();
      if (req_ready != '0) n++;
    end
    chk("bp_issues", n, 4);
    chk("bp_ready_low", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_head_id", rsp_id, 0);
    chk("bp_head_sum", rsp_sum, 16'h1000);
`ifdef ADDER_ARB_STATS_EN
    chk("bp_stat_issued", stat_issued, 14);
    st0 = stat_stall;
    nxt(); smp();
    chk("bp_stat_stall_inc", stat_stall, st0 + 16'd1);
`endif
    g.delete(); r.delete();
    for (int c = 0; c < 40 && !(r.size() >= 4 && g.size() >= 1); c++) begin
      nxt(); rsp_ready = 1'b1; smp();
      if (req_ready != '0) g.push_back(oh2i(req_ready));
      if (rsp_valid && rsp_ready) r.push_back(rsp_id);
    end
    chk("bp_resume_seen", g.size() >= 1, 1);
    chk("bp_drain_count", r.size() >= 4, 1);
    if (g.size() >= 1) chk("bp_resume_grant", g[0], 0);
    for (int k = 0; k < 4 && k < r.size(); k++) chk("bp_drain_id", r[k], k);
    for (int c = 0; c < 16; c++) begin
      nxt(); req_valid = '0; smp();
    end
    chk("drain_empty", rsp_valid, 0);

    // Reset mid-operation: two issues, idle cycle, one reset cycle.
    n = 0;
    nxt(); req_valid = 4'b0011; smp();
    if (req_ready != '0) n++;
    nxt(); smp();
    if (req_ready != '0) n++;
    chk("rm_issues", n, 2);
    nxt(); req_valid = '0; smp();
    nxt(); rst = 1'b1; req_valid = 4'b0100; smp();
    chk("rm_rst_ready", req_ready, 0);
    chk("rm_rst_vld", rsp_valid, 0);
    chk("rm_rst_add_y", add_y, 0);
    nxt(); rst = 1'b0; req_valid = 4'b1010; smp();
    chk("rm_first_grant", req_ready, 4'b0010);
`ifdef ADDER_ARB_STATS_EN
    chk("rm_stat_issued", stat_issued, 0);
    chk("rm_stat_stall", stat_stall, 0);
`endif
    for (int c = 5; c <= 9; c++) begin
      nxt(); req_valid = '0; smp();
      if (c < 9) begin
        chk("rm_no_stale", rsp_valid, 0);
      end else begin
        chk("rm_new_vld", rsp_valid, 1);
        chk("rm_new_id", rsp_id, 1);
        chk("rm_new_sum", rsp_sum, 16'h2001);
      end
    end
    nxt(); smp();
    chk("rm_end_empty", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
